// File: rtl/pmod_ad1_array.sv
// N-channel PmodAD1 sampler with baseline-calibrated level and hit detection (PEAK_HOLD_EN: running-peak level).
// One frame every QUIET+32*CLK_DIV+1 clk; outputs update together with the sample_valid pulse; no backpressure.
module pmod_ad1_array #(
    parameter int          N_CH    = 5,
    parameter int          CLK_DIV = 4,
    parameter int          QUIET   = 8,
    parameter logic [7:0]  THRESH  = 8'd40,
    parameter logic [15:0] HOLDOFF = 16'd500
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH-1:0]      sdata,
    input  logic [N_CH-1:0]      calibrate,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [12*N_CH-1:0]   sample,
    output logic                 sample_valid,
    output logic [8*N_CH-1:0]    level,
    output logic [N_CH-1:0]      hit
);

    localparam int QW = $clog2(QUIET);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {QUIET_S, CONV, LATCH} state_t;

    state_t               r_state;
    logic [QW-1:0]        r_qcnt;
    logic [DW-1:0]        r_div;
    logic [3:0]           r_bit;
    logic                 r_cs_n;
    logic                 r_sclk;
    logic                 r_valid;
    logic [N_CH-1:0]      r_hit;
    logic [12*N_CH-1:0]   r_sample;
    logic [8*N_CH-1:0]    r_level;
    logic [11:0]          r_shift [N_CH];
    logic [11:0]          r_base  [N_CH];
    logic [15:0]          r_hold  [N_CH];

    logic [11:0]          w_diff  [N_CH];
    logic [7:0]           w_lvl   [N_CH];
    logic [N_CH-1:0]      w_hit;

    // The 12-bit shifter lets the four leading zero bits fall off the top.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_diff[i] = (r_shift[i] >= r_base[i]) ? (r_shift[i] - r_base[i])
                                                  : (r_base[i] - r_shift[i]);
            w_lvl[i]  = 8'(w_diff[i] >> 4);
            w_hit[i]  = !calibrate[i] && (w_lvl[i] >= THRESH) && (r_hold[i] == 16'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= QUIET_S;
            r_qcnt   <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b1;
            r_valid  <= 1'b0;
            r_hit    <= '0;
            r_sample <= '0;
            r_level  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_shift[i] <= '0;
                r_base[i]  <= 12'h800;
                r_hold[i]  <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_hit   <= '0;
            case (r_state)
                QUIET_S: begin
                    if (r_qcnt == QW'(QUIET - 1)) begin
                        r_state <= CONV;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_qcnt <= r_qcnt + 1'b1;
                    end
                end
                CONV: begin
                    if (r_div == DW'(CLK_DIV - 1)) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            for (int i = 0; i < N_CH; i++)
                                r_shift[i] <= {r_shift[i][10:0], sdata[i]};
                        end else if (r_bit == 4'd15) begin
                            r_state <= LATCH;
                            r_cs_n  <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            r_bit  <= r_bit + 4'd1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                LATCH: begin
                    r_state <= QUIET_S;
                    r_qcnt  <= '0;
                    r_valid <= 1'b1;
                    r_hit   <= w_hit;
                    for (int i = 0; i < N_CH; i++) begin
                        r_sample[12*i +: 12] <= r_shift[i];
                        if (calibrate[i]) begin
                            r_base[i]          <= r_shift[i];
                            r_level[8*i +: 8]  <= 8'd0;
                        end else begin
`ifdef PEAK_HOLD_EN
                            if (w_hit[i] || (w_lvl[i] > r_level[8*i +: 8]))
                                r_level[8*i +: 8] <= w_lvl[i];
`else
                            r_level[8*i +: 8] <= w_lvl[i];
`endif
                        end
                        if (w_hit[i])
                            r_hold[i] <= HOLDOFF;
                        else if (r_hold[i] != 16'd0)
                            r_hold[i] <= r_hold[i] - 16'd1;
                    end
                end
                default: r_state <= QUIET_S;
            endcase
        end
    end

    assign cs_n         = r_cs_n;
    assign sclk         = r_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign level        = r_level;
    assign hit          = r_hit;

endmodule

// File: tb/tb_pmod_ad1_array.sv
// Bench for pmod_ad1_array: converter models on each sdata line, frame-level reference model, random frames.
module tb_pmod_ad1_array;

    localparam int          N_CH    = 5;
    localparam int          CLK_DIV = 4;
    localparam int          QUIET   = 8;
    localparam logic [7:0]  THRESH  = 8'd40;
    localparam logic [15:0] HOLDOFF = 16'd3;
    localparam int          FRAME   = QUIET + 32*CLK_DIV + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N_CH-1:0]      sdata;
    logic [N_CH-1:0]      calibrate;
    logic                 cs_n;
    logic                 sclk;
    logic [12*N_CH-1:0]   sample;
    logic                 sample_valid;
    logic [8*N_CH-1:0]    level;
    logic [N_CH-1:0]      hit;

    pmod_ad1_array #(
        .N_CH(N_CH), .CLK_DIV(CLK_DIV), .QUIET(QUIET), .THRESH(THRESH), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sdata(sdata), .calibrate(calibrate),
        .cs_n(cs_n), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
        .level(level), .hit(hit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Converter model: each channel returns {4'b0, cur_val} MSB first, one bit per sclk rise.
    logic [11:0] cur_val [N_CH];
    int          rise_cnt = 0;
    logic        sclk_q   = 1'b1;
    logic        cs_q     = 1'b1;

    always @(posedge clk) begin
        sclk_q <= sclk;
        cs_q   <= cs_n;
        if (cs_q && !cs_n)
            rise_cnt <= 0;
        else if (!cs_n && sclk && !sclk_q)
            rise_cnt <= rise_cnt + 1;
    end

    always_comb begin
        sdata = '0;
        for (int i = 0; i < N_CH; i++)
            if (rise_cnt >= 4 && rise_cnt < 16)
                sdata[i] = cur_val[i][15 - rise_cnt];
    end

    // Frame-level reference: baseline, hold-off frames remaining and displayed level per channel.
    int m_base [N_CH];
    int m_hold [N_CH];
    int m_lvl  [N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_base[i] = 'h800;
            m_hold[i] = 0;
            m_lvl[i]  = 0;
        end
    endtask

    task automatic model_frame(output logic [12*N_CH-1:0] es, output logic [8*N_CH-1:0] el,
                               output logic [N_CH-1:0] eh);
        int s, d, ln;
        bit h;
        for (int i = 0; i < N_CH; i++) begin
            s = int'(cur_val[i]);
            es[12*i +: 12] = cur_val[i];
            if (calibrate[i]) begin
                m_base[i] = s;
                ln = 0;
                h  = 1'b0;
            end else begin
                d  = s - m_base[i];
                if (d < 0) d = -d;
                ln = d / 16;
                h  = (ln >= int'(THRESH)) && (m_hold[i] == 0);
            end
            if (h) m_hold[i] = int'(HOLDOFF);
            else if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
`ifdef PEAK_HOLD_EN
            if (h || calibrate[i] || ln > m_lvl[i]) m_lvl[i] = ln;
`else
            m_lvl[i] = ln;
`endif
            el[8*i +: 8] = 8'(m_lvl[i]);
            eh[i] = h;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sample_valid && n < 1000);
        chk("valid_seen", sample_valid, 1);
    endtask

    task automatic check_frame(input string tag, output int n);
        logic [12*N_CH-1:0] es;
        logic [8*N_CH-1:0]  el;
        logic [N_CH-1:0]    eh;
        wait_valid(n);
        model_frame(es, el, eh);
        chk({tag, "_sample"}, sample, es);
        chk({tag, "_level"}, level, el);
        chk({tag, "_hit"}, hit, eh);
        chk({tag, "_rises"}, rise_cnt, 16);
    endtask

    initial begin
        int n;
        reset_n   = 1'b1;
        calibrate = '0;
        for (int i = 0; i < N_CH; i++) cur_val[i] = 12'h800;
        cur_val[0] = 12'hABC;
        cur_val[1] = 12'hF00;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_sample", sample, 0);
        chk("rst_level", level, 0);
        chk("rst_hit", hit, 0);
        chk("rst_valid", sample_valid, 0);

        @(negedge clk) reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cs_n && n < 200);
        chk("quiet_len", n, QUIET);

        check_frame("frA", n);
        chk("frA_const", sample[23:0], 24'hF00ABC);
        check_frame("frB", n);
        chk("period", n, FRAME);

        cur_val[0] = 12'h7F0;
        calibrate  = 5'b00001;
        check_frame("cal", n);
        chk("cal_lvl0", level[7:0], 8'h00);
        calibrate  = '0;
        cur_val[0] = 12'h9F0;
        check_frame("cal2", n);
        chk("cal2_lvl0", level[7:0], 8'h20);
        chk("cal2_hit0", hit[0], 0);

        cur_val[0] = 12'h800;
        calibrate  = 5'b00001;
        check_frame("rebase", n);
        calibrate  = '0;
        for (int k = 0; k < 5; k++) begin
            cur_val[0] = 12'hB00;
            check_frame("hold", n);
            chk("hold_lvl0", level[7:0], 8'h30);
            chk("hold_hit0", hit[0], (k == 0 || k == 4) ? 1 : 0);
        end

        for (int i = 0; i < N_CH; i++) cur_val[i] = 12'h800;
        repeat (4) check_frame("settle", n);
        for (int i = 0; i < N_CH; i++) cur_val[i] = 12'hC00;
        check_frame("simul", n);
        chk("simul_hit", hit, 5'b11111);
        @(posedge clk);
        #1;
        chk("hit_pulse", hit, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N_CH; i++) begin
                cur_val[i]   = 12'($urandom_range(0, 4095));
                calibrate[i] = ($urandom_range(0, 5) == 0);
            end
            check_frame("rand", n);
        end

        calibrate = '0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(cs_n == 1'b0 && rise_cnt == 7) && n < 500);
        chk("rise7_reached", rise_cnt, 7);
        reset_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 1);
        chk("abort_valid", sample_valid, 0);
        model_reset();
        repeat (3) @(posedge clk);
        for (int i = 0; i < N_CH; i++) cur_val[i] = 12'h800;
        cur_val[0] = 12'hB00;
        @(negedge clk) reset_n = 1'b1;
        check_frame("post_rst", n);
        chk("post_rst_len", n, FRAME);
        cur_val[0] = 12'h900;
        check_frame("drop", n);
`ifdef PEAK_HOLD_EN
        chk("drop_lvl0", level[7:0], 8'h30);
`else
        chk("drop_lvl0", level[7:0], 8'h10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
